// File: rtl/at24c02_pkg.sv
// Shared types and constants for the AT24C02 I2C slave model.
package at24c02_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEVADDR,
      ST_ACK_DEV,
      ST_WORDADDR,
      ST_ACK_WORD,
      ST_WRDATA,
      ST_ACK_WR,
      ST_RDDATA,
      ST_RDACK,
      ST_IGNORE
   } i2c_slv_state_t;

   localparam logic [6:0] AT24_DEV_ADDR  = 7'h50;
   localparam int         AT24_PAGE_SIZE = 8;
   localparam logic       ACK_BIT        = 1'b0;
   localparam logic       NACK_BIT       = 1'b1;

endpackage

// File: rtl/at24c02_sim_bus_cond.sv
// I2C line conditioning: 2-FF synchronizers, 3-sample majority filter,
// SCL edge and START/STOP detection on the filtered lines.
module i2c_bus_cond (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start,
   output logic stop
);

   logic       scl_p0, scl_p1, sda_p0, sda_p1;
   logic [1:0] scl_h, sda_h;
   logic       scl_f, sda_f, scl_fq, sda_fq;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Lines idle high, so every stage resets to 1 to avoid a phantom START.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_p0 <= 1'b1;
         scl_p1 <= 1'b1;
         sda_p0 <= 1'b1;
         sda_p1 <= 1'b1;
         scl_h  <= 2'b11;
         sda_h  <= 2'b11;
         scl_f  <= 1'b1;
         sda_f  <= 1'b1;
         scl_fq <= 1'b1;
         sda_fq <= 1'b1;
      end else begin
         scl_p0 <= scl_i;
         scl_p1 <= scl_p0;
         sda_p0 <= sda_i;
         sda_p1 <= sda_p0;
         scl_h  <= {scl_h[0], scl_p1};
         sda_h  <= {sda_h[0], sda_p1};
         scl_f  <= maj3(scl_p1, scl_h[0], scl_h[1]);
         sda_f  <= maj3(sda_p1, sda_h[0], sda_h[1]);
         scl_fq <= scl_f;
         sda_fq <= sda_f;
      end
   end

   assign scl_rise = scl_f & ~scl_fq;
   assign scl_fall = ~scl_f & scl_fq;
   assign sda_s    = sda_f;
   assign start    = scl_f & scl_fq & sda_fq & ~sda_f;
   assign stop     = scl_f & scl_fq & ~sda_fq & sda_f;

endmodule

// File: rtl/at24c02_sim.sv
// AT24C02 256-byte I2C EEPROM slave model: byte/page write, current,
// random and sequential read, with a post-write busy window for ACK polling.
module at24c02_sim
   import at24c02_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR  = AT24_DEV_ADDR,
   parameter int         MEM_DEPTH = 256,
   parameter int         PAGE_SIZE = AT24_PAGE_SIZE,
   parameter int         WR_CYCLES = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o,
   output logic       sda_oe,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

   localparam int         BUSY_W    = $clog2(WR_CYCLES + 1);
   localparam logic [7:0] PAGE_MASK = 8'(PAGE_SIZE - 1);
   localparam logic [7:0] ADDR_MASK = 8'(MEM_DEPTH - 1);

   logic scl_rise, scl_fall, sda_s, start, stop;

   i2c_bus_cond u_cond (
      .clk      (clk),
      .rst      (rst),
      .scl_i    (scl_i),
      .sda_i    (sda_i),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .sda_s    (sda_s),
      .start    (start),
      .stop     (stop)
   );

   i2c_slv_state_t    state;
   logic [2:0]        bit_cnt;
   logic [7:0]        shreg;
   logic [7:0]        ptr;
   logic [7:0]        rd_byte;
   logic [BUSY_W-1:0] busy_cnt;
   logic              ack_phase, rd_ack, wr_pending, rw;
   logic [7:0]        rx_byte;
   logic              wr_fire;

   logic [7:0] mem [MEM_DEPTH] = '{default: 8'hFF};

   function automatic logic [7:0] page_next(input logic [7:0] a);
      return (a & ~PAGE_MASK) | ((a + 8'd1) & PAGE_MASK);
   endfunction

   assign rx_byte = {shreg[6:0], sda_s};
   assign wr_fire = !rst && (state == ST_WRDATA) && scl_rise && (bit_cnt == 3'd7);
   assign sda_o   = 1'b0;
   assign busy    = (busy_cnt != '0);

   // Storage is non-volatile: no reset, registered read port.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[ptr] <= rx_byte;
      rd_byte <= mem[ptr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         sda_oe     <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= 8'h00;
         wr_data    <= 8'h00;
         busy_cnt   <= '0;
         ptr        <= 8'h00;
         bit_cnt    <= 3'd0;
         ack_phase  <= 1'b0;
         rd_ack     <= 1'b0;
         wr_pending <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (busy_cnt != '0) busy_cnt <= busy_cnt - BUSY_W'(1);
         if (stop) begin
            state     <= ST_IDLE;
            sda_oe    <= 1'b0;
            bit_cnt   <= 3'd0;
            ack_phase <= 1'b0;
            rd_ack    <= 1'b0;
            if (wr_pending) begin
               busy_cnt   <= BUSY_W'(WR_CYCLES);
               wr_pending <= 1'b0;
            end
         end else if (start) begin
            state     <= ST_DEVADDR;
            sda_oe    <= 1'b0;
            bit_cnt   <= 3'd0;
            ack_phase <= 1'b0;
            rd_ack    <= 1'b0;
         end else begin
            case (state)
               ST_DEVADDR: if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (rx_byte[7:1] == DEV_ADDR && busy_cnt == '0) begin
                        rw        <= rx_byte[0];
                        ack_phase <= 1'b0;
                        state     <= ST_ACK_DEV;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end
               end
               // First fall after the 8th bit drives ACK, the second releases it.
               ST_ACK_DEV: if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_oe    <= ~ACK_BIT;
                     ack_phase <= 1'b1;
                  end else begin
                     ack_phase <= 1'b0;
                     bit_cnt   <= 3'd0;
                     if (rw) begin
                        state  <= ST_RDDATA;
                        shreg  <= rd_byte;
                        sda_oe <= ~rd_byte[7];
                     end else begin
                        state  <= ST_WORDADDR;
                        sda_oe <= 1'b0;
                     end
                  end
               end
               ST_WORDADDR: if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ptr       <= rx_byte & ADDR_MASK;
                     ack_phase <= 1'b0;
                     state     <= ST_ACK_WORD;
                  end
               end
               ST_ACK_WORD, ST_ACK_WR: if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_oe    <= ~ACK_BIT;
                     ack_phase <= 1'b1;
                  end else begin
                     ack_phase <= 1'b0;
                     bit_cnt   <= 3'd0;
                     sda_oe    <= 1'b0;
                     state     <= ST_WRDATA;
                  end
               end
               ST_WRDATA: if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     wr_en      <= 1'b1;
                     wr_addr    <= ptr;
                     wr_data    <= rx_byte;
                     ptr        <= page_next(ptr);
                     wr_pending <= 1'b1;
                     ack_phase  <= 1'b0;
                     state      <= ST_ACK_WR;
                  end
               end
               ST_RDDATA: if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     sda_oe <= 1'b0;
                     rd_ack <= 1'b0;
                     state  <= ST_RDACK;
                  end else begin
                     shreg   <= {shreg[6:0], 1'b0};
                     sda_oe  <= ~shreg[6];
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
               // ptr moves on the master's ACK rise; rd_byte is ready by the next fall.
               ST_RDACK: begin
                  if (scl_rise) begin
                     ptr <= (ptr + 8'd1) & ADDR_MASK;
                     if (sda_s == NACK_BIT) state <= ST_IGNORE;
                     else rd_ack <= 1'b1;
                  end else if (scl_fall && rd_ack) begin
                     rd_ack  <= 1'b0;
                     state   <= ST_RDDATA;
                     shreg   <= rd_byte;
                     sda_oe  <= ~rd_byte[7];
                     bit_cnt <= 3'd0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_at24c02_sim.sv
// Directed bit-banged I2C master bench for the AT24C02 slave model.
module tb_at24c02_sim;

   localparam int   Q = 10;
   localparam logic A = 1'b0;
   localparam logic N = 1'b1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_bus;
   logic       sda_o, sda_oe, wr_en, busy;
   logic [7:0] wr_addr, wr_data;

   int checks = 0, failures = 0;
   int oe_cnt = 0, wr_cnt = 0, busy_cyc = 0, wr_run = 0, wr_run_max = 0;
   logic [7:0] last_wa = 8'h00, last_wd = 8'h00;

   always #5 clk = ~clk;
   assign sda_bus = m_sda & ~sda_oe;

   at24c02_sim #(
      .DEV_ADDR  (7'h50),
      .MEM_DEPTH (256),
      .PAGE_SIZE (8),
      .WR_CYCLES (500)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .scl_i   (m_scl),
      .sda_i   (sda_bus),
      .sda_o   (sda_o),
      .sda_oe  (sda_oe),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy)
   );

   always @(negedge clk) begin
      if (sda_oe === 1'b1) oe_cnt++;
      if (busy === 1'b1) busy_cyc++;
      if (wr_en === 1'b1) begin
         wr_cnt++;
         last_wa = wr_addr;
         last_wd = wr_data;
         wr_run++;
         if (wr_run > wr_run_max) wr_run_max = wr_run;
      end else begin
         wr_run = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic wr_bit(input logic b);
      m_sda = b; wq(); m_scl = 1'b1; wq(); wq(); m_scl = 1'b0; wq();
   endtask

   task automatic rd_bit(output logic b);
      m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); b = sda_bus; wq(); m_scl = 1'b0; wq();
   endtask

   task automatic i2c_start();
      m_scl = 1'b0; m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); m_sda = 1'b0; wq(); m_scl = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      m_scl = 1'b0; m_sda = 1'b0; wq(); m_scl = 1'b1; wq(); m_sda = 1'b1; wq(); wq();
   endtask

   task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string tag);
      logic b;
      for (int i = 7; i >= 0; i--) wr_bit(d[i]);
      rd_bit(b);
      chk(tag, 32'(b), 32'(exp_ack));
   endtask

   task automatic recv_byte(input logic ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         rd_bit(b);
         d[i] = b;
      end
      wr_bit(ack);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("busy_clear", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] d;
      logic       b;
      int         s_wr, s_oe, s_busy;

      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_sda_oe", 32'(sda_oe), 32'd0);
      chk("rst_sda_o", 32'(sda_o), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Byte write 0xA5 at 0x10
      s_wr = wr_cnt;
      i2c_start();
      send_byte(8'hA0, A, "bw_dev");
      send_byte(8'h10, A, "bw_word");
      send_byte(8'hA5, A, "bw_data");
      chk("bw_wr_cnt", 32'(wr_cnt - s_wr), 32'd1);
      chk("bw_wr_addr", 32'(last_wa), 32'h10);
      chk("bw_wr_data", 32'(last_wd), 32'hA5);
      s_busy = busy_cyc;
      i2c_stop();
      chk("bw_busy_set", 32'(busy), 32'd1);
      wait_idle();
      chk("bw_busy_len", 32'(busy_cyc - s_busy), 32'd500);

      // Random read of 0x10
      s_wr = wr_cnt;
      i2c_start();
      send_byte(8'hA0, A, "rr_dev_w");
      send_byte(8'h10, A, "rr_word");
      i2c_start();
      send_byte(8'hA1, A, "rr_dev_r");
      recv_byte(N, d);
      i2c_stop();
      chk("rr_data", 32'(d), 32'hA5);
      chk("rr_no_write", 32'(wr_cnt - s_wr), 32'd0);
      chk("rr_no_busy", 32'(busy), 32'd0);

      // Page write wrapping inside page 0x00-0x07
      s_wr = wr_cnt;
      i2c_start();
      send_byte(8'hA0, A, "pw_dev");
      send_byte(8'h06, A, "pw_word");
      send_byte(8'h11, A, "pw_d0");
      send_byte(8'h22, A, "pw_d1");
      send_byte(8'h33, A, "pw_d2");
      send_byte(8'h44, A, "pw_d3");
      chk("pw_wr_cnt", 32'(wr_cnt - s_wr), 32'd4);
      chk("pw_last_addr", 32'(last_wa), 32'h01);
      chk("pw_last_data", 32'(last_wd), 32'h44);
      i2c_stop();

      // ACK polling during the write cycle
      repeat (4) @(negedge clk);
      s_oe = oe_cnt;
      i2c_start();
      send_byte(8'hA0, N, "poll_busy_nack");
      chk("poll_busy_no_drive", 32'(oe_cnt - s_oe), 32'd0);
      i2c_stop();
      wait_idle();
      i2c_start();
      send_byte(8'hA0, A, "poll_ready_ack");
      i2c_stop();
      chk("poll_no_busy", 32'(busy), 32'd0);

      i2c_start();
      send_byte(8'hA0, A, "pr0_dev_w");
      send_byte(8'h00, A, "pr0_word");
      i2c_start();
      send_byte(8'hA1, A, "pr0_dev_r");
      recv_byte(A, d);
      chk("pw_rd_00", 32'(d), 32'h33);
      recv_byte(N, d);
      chk("pw_rd_01", 32'(d), 32'h44);
      i2c_stop();

      i2c_start();
      send_byte(8'hA0, A, "pr6_dev_w");
      send_byte(8'h06, A, "pr6_word");
      i2c_start();
      send_byte(8'hA1, A, "pr6_dev_r");
      recv_byte(A, d);
      chk("pw_rd_06", 32'(d), 32'h11);
      recv_byte(N, d);
      chk("pw_rd_07", 32'(d), 32'h22);
      i2c_stop();

      // Sequential read rolling over 0xFF -> 0x00
      i2c_start();
      send_byte(8'hA0, A, "sq_dev_w");
      send_byte(8'hFE, A, "sq_word");
      send_byte(8'h5A, A, "sq_d0");
      send_byte(8'hC3, A, "sq_d1");
      i2c_stop();
      wait_idle();
      i2c_start();
      send_byte(8'hA0, A, "sq_rd_dev_w");
      send_byte(8'hFE, A, "sq_rd_word");
      i2c_start();
      send_byte(8'hA1, A, "sq_rd_dev_r");
      recv_byte(A, d);
      chk("sq_rd_fe", 32'(d), 32'h5A);
      recv_byte(A, d);
      chk("sq_rd_ff", 32'(d), 32'hC3);
      recv_byte(N, d);
      chk("sq_rd_00", 32'(d), 32'h33);
      i2c_stop();
      i2c_start();
      send_byte(8'hA1, A, "cur_dev_r");
      recv_byte(N, d);
      chk("cur_rd_01", 32'(d), 32'h44);
      i2c_stop();

      // Address mismatch
      s_oe = oe_cnt;
      s_wr = wr_cnt;
      i2c_start();
      send_byte(8'hA2, N, "mm_dev");
      send_byte(8'h10, N, "mm_word");
      send_byte(8'h77, N, "mm_data");
      i2c_stop();
      chk("mm_no_drive", 32'(oe_cnt - s_oe), 32'd0);
      chk("mm_no_write", 32'(wr_cnt - s_wr), 32'd0);
      chk("mm_no_busy", 32'(busy), 32'd0);

      // Reset in the middle of a read data byte
      i2c_start();
      send_byte(8'hA0, A, "rm_dev_w");
      send_byte(8'h10, A, "rm_word");
      i2c_start();
      send_byte(8'hA1, A, "rm_dev_r");
      rd_bit(b);
      rd_bit(b);
      rd_bit(b);
      chk("rm_driving_bit4", 32'(sda_oe), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rm_release", 32'(sda_oe), 32'd0);
      chk("rm_wr_addr_rst", 32'(wr_addr), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      i2c_stop();
      i2c_start();
      send_byte(8'hA1, A, "rm_cur_dev_r");
      recv_byte(N, d);
      chk("rm_cur_rd_00", 32'(d), 32'h33);
      i2c_stop();
      i2c_start();
      send_byte(8'hA0, A, "rm2_dev_w");
      send_byte(8'h10, A, "rm2_word");
      i2c_start();
      send_byte(8'hA1, A, "rm2_dev_r");
      recv_byte(N, d);
      chk("rm_rd_10", 32'(d), 32'hA5);
      i2c_stop();

      chk("wr_en_width", 32'(wr_run_max), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
